bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-add-3 (double dabble) algorithm, one bit per clock. It produces the packed BCD digits consumed by the per-digit 7-segment display decoders, and sits between the datapath result register and the display stage. A start/busy/done handshake lets the controller launch a conversion and latch the result.

Parameters:
- W, 16, width of the binary input.
- DIGITS, 5, number of BCD digits produced; must satisfy DIGITS >= 1.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request conversion of bin_in; sampled only when the block is ready.
- bin_in, input, W, unsigned binary value, captured on the accepted start.
- busy, output, 1, high while a conversion is in progress.
- done, output, 1, one-cycle pulse when bcd_out/overflow are updated.
- bcd_out, output, 4*DIGITS, packed BCD; digit 0 (units) in bits [3:0]; held until the next done.
- overflow, output, 1, value did not fit in DIGITS digits; updated with done.

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE, busy=0, done=0, bcd_out=0, overflow=0, and clears the internal shift/bit counters. Reset mid-conversion aborts it; no done is issued.
- States:
  - IDLE: ready; start=1 at edge N loads shift_reg=bin_in, scratch BCD=0, count=W, ovf_acc=0, and goes to SHIFT. busy=1 from cycle N+1.
  - SHIFT: each cycle, every scratch digit >=5 gets +3. Then {scratch, shift_reg} shifts left one bit and count decrements. The bit shifted out of the top digit ORs into ovf_acc. When count reaches 1 on this cycle, go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle. bcd_out/overflow are registered on entry, so they are valid the same cycle done is high. Next state is IDLE, or SHIFT if start=1, which gives back-to-back conversions.
- Latency: start edge N -> done high in cycle N+W+1. Throughput: one conversion per W+1 cycles.
- start is ignored while busy=1; bin_in is don't-care except on the accepted edge.
- Add-3 correction is applied before the shift, on 4-bit digits. Digits never exceed 9 after the shift when no overflow occurs.
- Overflow: set when any 1 is shifted out of digit DIGITS-1. bcd_out then holds the value modulo 10^DIGITS.
- Zero input yields all-zero digits, overflow=0.

Optional Feature:
- Macro: BCD_LEADING_BLANK_EN.
- Defined: on DONE, every digit above the most significant nonzero digit is replaced by 4'hF. Digit 0 is never blanked, so 0 shows "0". The downstream decoder's default case then drives the segments dark.
- Not defined: leading zeros are output as 4'h0.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package/include bcd_pkg:
  - state encodings ST_IDLE/ST_SHIFT/ST_DONE
  - BCD_BLANK = 4'hF
  - digit width constant 4
- One natural sub-module: bcd_add3, a combinational 4-bit cell (out = in>=5 ? in+3 : in), instantiated DIGITS times via generate.

Test Plan:
- W=16/DIGITS=5: start with bin_in=0 -> done at N+17, bcd_out=20'h00000, overflow=0. With the macro: 20'hFFFF0.
- bin_in=65535 -> bcd_out=20'h65535, overflow=0; busy high for exactly 16 cycles.
- bin_in=1234, then start pulsed again at N+5 with bin_in=9999 -> second start ignored, bcd_out=20'h01234 (macro: 20'hF1234).
- W=8/DIGITS=2: bin_in=255 -> overflow=1, bcd_out=8'h55; bin_in=99 -> overflow=0, bcd_out=8'h99.
- bin_in=4321, rst_n asserted at N+8 for 2 cycles -> busy=0, bcd_out=0, no done pulse. A fresh start with 42 -> bcd_out=20'h00042.
- start held high continuously with 7, then 8 -> done pulses every 17 cycles with 20'h00007, then 20'h00008.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared encodings and constants for the sequential binary-to-BCD converter
//
// Contents:
//   DIGIT_W   - width of one packed BCD digit
//   BCD_BLANK - digit code the display decoder renders dark
//   state_e   - converter FSM states ST_IDLE / ST_SHIFT / ST_DONE

package bcd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - combinational add-3 correction cell for one BCD digit
//
// Ports:
//   din  - scratch digit before the shift
//   dout - din + 3 when din >= 5, else din unchanged

module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    // A digit >= 5 would become >= 10 after the doubling shift; adding 3
    // first makes the shift carry cleanly into the next digit.
    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-add-3 binary-to-BCD converter, one bit per clock
//
// Parameters:
//   W      - width of the binary input
//   DIGITS - number of BCD digits produced (>= 1)
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset; aborts any conversion
//   start    - launch a conversion of bin_in; only sampled in IDLE or DONE
//   bin_in   - unsigned binary value captured on the accepted start
//   busy     - high while bits are being shifted
//   done     - one-cycle pulse when bcd_out / overflow are updated
//   bcd_out  - packed BCD, digit 0 (units) in bits [3:0]; held until the next done
//   overflow - value did not fit in DIGITS digits (bcd_out is then value mod 10^DIGITS)
//
// Build option:
//   BCD_LEADING_BLANK_EN - when defined, digits above the most significant
//   nonzero digit are replaced by BCD_BLANK; digit 0 is never blanked.

module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int W      = 16,
    parameter int DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [W-1:0]              bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                      overflow
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(W + 1);

    state_e             state_q,    state_d;
    logic [W-1:0]       shift_q,    shift_d;
    logic [BCD_W-1:0]   scratch_q,  scratch_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic               ovf_acc_q,  ovf_acc_d;
    logic [BCD_W-1:0]   bcd_q,      bcd_d;
    logic               overflow_q, overflow_d;

    logic [BCD_W-1:0]   corrected;
    logic [BCD_W-1:0]   scratch_next;
    logic [W-1:0]       shift_next;
    logic               ovf_next;
    logic [BCD_W-1:0]   final_bcd;
    logic               load;

    // Add-3 correction on every scratch digit, ahead of the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .dout (corrected[g*DIGIT_W +: DIGIT_W])
        );
    end

    // {scratch, shift} shifted left one bit; the bit leaving the top digit
    // is lost from the result and recorded as overflow.
    assign scratch_next = {corrected[BCD_W-2:0], shift_q[W-1]};
    assign shift_next   = shift_q << 1;
    assign ovf_next     = ovf_acc_q | corrected[BCD_W-1];

`ifdef BCD_LEADING_BLANK_EN
    logic blank_seen;

    // Scan from the top digit down; zeros are blanked until the first
    // nonzero digit. Digit 0 is excluded so a zero result still shows "0".
    always_comb begin
        blank_seen = 1'b0;
        final_bcd  = scratch_next;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (!blank_seen && (scratch_next[d*DIGIT_W +: DIGIT_W] == '0)) begin
                final_bcd[d*DIGIT_W +: DIGIT_W] = BCD_BLANK;
            end else begin
                blank_seen = 1'b1;
            end
        end
    end
`else
    assign final_bcd = scratch_next;
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        count_d    = count_q;
        ovf_acc_d  = ovf_acc_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        load       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                load = start;
            end
            ST_SHIFT: begin
                shift_d   = shift_next;
                scratch_d = scratch_next;
                ovf_acc_d = ovf_next;
                count_d   = count_q - CNT_W'(1);
                // count_q == 1 means this cycle shifts the last input bit,
                // so the result registers are loaded on the way into DONE.
                if (count_q == CNT_W'(1)) begin
                    state_d    = ST_DONE;
                    bcd_d      = final_bcd;
                    overflow_d = ovf_next;
                end
            end
            ST_DONE: begin
                // Accepting start here gives back-to-back conversions.
                load    = start;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            state_d   = ST_SHIFT;
            shift_d   = bin_in;
            scratch_d = '0;
            count_d   = CNT_W'(W);
            ovf_acc_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            count_q    <= '0;
            ovf_acc_q  <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            count_q    <= count_d;
            ovf_acc_q  <= ovf_acc_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);
    assign bcd_out  = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed self-checking bench for bin_to_bcd_seq (16/5 and 8/2 builds)

module tb_bin_to_bcd_seq;

`ifdef BCD_LEADING_BLANK_EN
    localparam logic [19:0] E_ZERO = 20'hFFFF0;
    localparam logic [19:0] E_1234 = 20'hF1234;
    localparam logic [19:0] E_42   = 20'hFFF42;
    localparam logic [19:0] E_7    = 20'hFFFF7;
    localparam logic [19:0] E_8    = 20'hFFFF8;
`else
    localparam logic [19:0] E_ZERO = 20'h00000;
    localparam logic [19:0] E_1234 = 20'h01234;
    localparam logic [19:0] E_42   = 20'h00042;
    localparam logic [19:0] E_7    = 20'h00007;
    localparam logic [19:0] E_8    = 20'h00008;
`endif

    logic        clk;
    logic        rst_n;

    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [19:0] bcd_out;
    logic        overflow;

    logic        start8;
    logic [7:0]  bin8;
    logic        busy8;
    logic        done8;
    logic [7:0]  bcd8;
    logic        ovf8;

    int n_vec;
    int n_err;

    bin_to_bcd_seq #(.W(16), .DIGITS(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    bin_to_bcd_seq #(.W(8), .DIGITS(2)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start8),
        .bin_in   (bin8),
        .busy     (busy8),
        .done     (done8),
        .bcd_out  (bcd8),
        .overflow (ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one conversion on the 16-bit instance; optionally pulse start
    // again (with extra_v) at loop cycle extra_at. lat = cycles after the
    // accepting edge until done is seen (0 = timeout).
    task automatic run16(input logic [15:0] v, input int extra_at, input logic [15:0] extra_v,
                         output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = (i == extra_at);
            if (i == extra_at) bin_in = extra_v;
            if (busy) busy_n++;
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic run8(input logic [7:0] v, output int lat);
        lat = 0;
        @(negedge clk);
        start8 = 1'b1;
        bin8   = v;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) begin
                lat = i;
                break;
            end
        end
        start8 = 1'b0;
    endtask

    initial begin
        int lat;
        int busy_n;
        int first;
        int second;
        int n_done;

        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        start8 = 1'b0;
        bin8   = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_bcd", bcd_out, 0);
        check_eq("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // zero input
        run16(16'd0, 0, 16'd0, lat, busy_n);
        check_eq("zero_lat", lat, 17);
        check_eq("zero_bcd", bcd_out, E_ZERO);
        check_eq("zero_ovf", overflow, 0);
        @(negedge clk);
        check_eq("zero_done_pulse", done, 0);

        // full-scale input
        run16(16'd65535, 0, 16'd0, lat, busy_n);
        check_eq("max_lat", lat, 17);
        check_eq("max_busy_cycles", busy_n, 16);
        check_eq("max_bcd", bcd_out, 20'h65535);
        check_eq("max_ovf", overflow, 0);
        @(negedge clk);
        check_eq("max_done_pulse", done, 0);
        check_eq("max_bcd_held", bcd_out, 20'h65535);

        // second start while busy is ignored
        run16(16'd1234, 5, 16'd9999, lat, busy_n);
        check_eq("ign_lat", lat, 17);
        check_eq("ign_bcd", bcd_out, E_1234);
        check_eq("ign_ovf", overflow, 0);
        @(negedge clk);
        check_eq("ign_idle", busy, 0);

        // 8-bit / 2-digit instance: overflow and largest fitting value
        run8(8'd255, lat);
        check_eq("w8_255_lat", lat, 9);
        check_eq("w8_255_bcd", bcd8, 8'h55);
        check_eq("w8_255_ovf", ovf8, 1);
        @(negedge clk);
        run8(8'd99, lat);
        check_eq("w8_99_lat", lat, 9);
        check_eq("w8_99_bcd", bcd8, 8'h99);
        check_eq("w8_99_ovf", ovf8, 0);
        @(negedge clk);

        // reset in the middle of a conversion
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd4321;
        @(negedge clk);
        start  = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_bcd", bcd_out, 0);
        check_eq("abort_ovf", overflow, 0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check_eq("abort_no_done", n_done, 0);
        run16(16'd42, 0, 16'd0, lat, busy_n);
        check_eq("after_abort_lat", lat, 17);
        check_eq("after_abort_bcd", bcd_out, E_42);
        @(negedge clk);

        // start held high: back-to-back conversions
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd7;
        first  = 0;
        second = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) bin_in = 16'd8;
            if (done) begin
                if (first == 0) begin
                    first = i;
                    check_eq("b2b_first_bcd", bcd_out, E_7);
                end else begin
                    second = i;
                    check_eq("b2b_second_bcd", bcd_out, E_8);
                    break;
                end
            end
        end
        start = 1'b0;
        check_eq("b2b_first_lat", first, 17);
        check_eq("b2b_period", second - first, 17);
        repeat (2) @(negedge clk);
        check_eq("b2b_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
